// File: rtl/fountain_v1_pkg.sv
// Shared definitions for the fountain_v1 LT decoder slice.
// Holds the default generation size, the FSM state encodings and a helper
// that gives an index width that never collapses to zero bits.
package fountain_v1_pkg;

  localparam int K_DEF = 8;   // source blocks per generation
  localparam int W_DEF = 64;  // payload width

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCEPT  = 3'd1;
  localparam logic [2:0] ST_REDUCE  = 3'd2;
  localparam logic [2:0] ST_BACKSUB = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDXW = idx_w(K_DEF);

endpackage

// File: rtl/fountain_v1_if.sv
// Symbol-in / block-out handshake bundle for the fountain_v1 decoder.
//   sym_valid/sym_ready/sym_mask/sym_data : coded symbols toward the decoder
//   src_valid/src_ready/src_index/src_data: recovered blocks toward the consumer
// master = symbol source + block consumer, slave = decoder.
interface fountain_v1_if
  import fountain_v1_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int W = W_DEF
);
  localparam int IW = idx_w(K);

  logic          sym_valid;
  logic          sym_ready;
  logic [K-1:0]  sym_mask;
  logic [W-1:0]  sym_data;
  logic          src_valid;
  logic          src_ready;
  logic [IW-1:0] src_index;
  logic [W-1:0]  src_data;

  modport master (
    output sym_valid, sym_mask, sym_data, src_ready,
    input  sym_ready, src_valid, src_index, src_data
  );

  modport slave (
    input  sym_valid, sym_mask, sym_data, src_ready,
    output sym_ready, src_valid, src_index, src_data
  );
endinterface

// File: rtl/fountain_v1_bitfind.sv
// Combinational first-set-bit finder.
//   vec   : input bit vector (N bits)
//   found : any bit set
//   idx   : lowest set bit (MSB_FIRST=0) or highest set bit (MSB_FIRST=1); 0 if none
module fountain_v1_bitfind
  import fountain_v1_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
)(
  input  logic [N-1:0]        vec,
  output logic                found,
  output logic [idx_w(N)-1:0] idx
);
  localparam int IW = idx_w(N);

  // Last match in the scan order wins, so the scan direction is reversed
  // relative to the priority wanted.
  always_comb begin
    found = |vec;
    idx   = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = IW'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/fountain_v1_decoder.sv
// LT fountain decoder: online GF(2) elimination of incoming symbols into K
// pivot rows, back-substitution to the identity, then in-order block output.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, clears the decoder and opens a new generation
//   bus        : symbol input and recovered-block output handshakes (slave)
//   rank       : number of pivot rows filled
//   drop_cnt   : redundant/zero symbols discarded, saturating
//   done       : all K blocks delivered, held until start/reset
module fountain_v1_decoder
  import fountain_v1_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int W = W_DEF
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  fountain_v1_if.slave           bus,
  output logic [$clog2(K+1)-1:0] rank,
  output logic [15:0]            drop_cnt,
  output logic                   done
);
  localparam int IW = idx_w(K);
  localparam int RW = $clog2(K + 1);

  logic [2:0]    state;
  logic [K-1:0]  row_vld;
  logic [K-1:0]  row_mask [K];
  logic [W-1:0]  row_data [K];
  logic [K-1:0]  work_mask;
  logic [W-1:0]  work_data;
  logic [IW-1:0] idx;
  logic [IW-1:0] bs_p;

  logic          red_found;
  logic [IW-1:0] red_p;
  logic          bs_found;
  logic [IW-1:0] bs_h;
  logic [K-1:0]  above;
  logic [K-1:0]  bs_vec;

  fountain_v1_bitfind #(.N(K), .MSB_FIRST(1'b0)) u_find_low (
    .vec(work_mask), .found(red_found), .idx(red_p)
  );

  // Only bits strictly above the current row's pivot are eliminated.
  always_comb begin
    above = '0;
    for (int i = 0; i < K; i++) above[i] = (i > int'(bs_p));
    bs_vec = row_mask[bs_p] & above;
  end

  fountain_v1_bitfind #(.N(K), .MSB_FIRST(1'b1)) u_find_high (
    .vec(bs_vec), .found(bs_found), .idx(bs_h)
  );

  logic accept_fire, red_store, red_xor, bs_xor;
  assign accept_fire = (state == ST_ACCEPT) && bus.sym_valid;
  assign red_store   = (state == ST_REDUCE) && red_found && !row_vld[red_p];
  assign red_xor     = (state == ST_REDUCE) && red_found &&  row_vld[red_p];
  assign bs_xor      = (state == ST_BACKSUB) && bs_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      row_vld  <= '0;
      rank     <= '0;
      drop_cnt <= '0;
      idx      <= '0;
      bs_p     <= '0;
    end else if (start) begin
      state    <= ST_ACCEPT;
      row_vld  <= '0;
      rank     <= '0;
      drop_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        ST_ACCEPT: if (bus.sym_valid) state <= ST_REDUCE;
        ST_REDUCE: begin
          if (!red_found) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            state <= ST_ACCEPT;
          end else if (!row_vld[red_p]) begin
            row_vld[red_p] <= 1'b1;
            rank           <= rank + 1'b1;
            if (rank == RW'(K - 1)) begin
              state <= ST_BACKSUB;
              bs_p  <= IW'(K - 2);
            end else begin
              state <= ST_ACCEPT;
            end
          end
        end
        ST_BACKSUB: begin
          if (!bs_found) begin
            if (bs_p == '0) begin
              state <= ST_OUTPUT;
              idx   <= '0;
            end else begin
              bs_p <= bs_p - 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (bus.src_ready) begin
            if (idx == IW'(K - 1)) state <= ST_DONE;
            else                   idx   <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Row and work storage carry no reset; row_vld qualifies every row.
  always_ff @(posedge clk) begin
    if (accept_fire) begin
      work_mask <= bus.sym_mask;
      work_data <= bus.sym_data;
    end else if (red_xor) begin
      work_mask <= work_mask ^ row_mask[red_p];
      work_data <= work_data ^ row_data[red_p];
    end
    if (red_store) begin
      row_mask[red_p] <= work_mask;
      row_data[red_p] <= work_data;
    end
    if (bs_xor) begin
      row_mask[bs_p] <= row_mask[bs_p] ^ row_mask[bs_h];
      row_data[bs_p] <= row_data[bs_p] ^ row_data[bs_h];
    end
  end

  assign bus.sym_ready = (state == ST_ACCEPT);
  assign bus.src_valid = (state == ST_OUTPUT);
  assign bus.src_index = idx;
  assign bus.src_data  = (state == ST_OUTPUT) ? row_data[idx] : '0;
  assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_fountain_v1_decoder.sv
// Directed bench for fountain_v1_decoder (K=8, W=64): table of symbols with
// expected rank/drop_cnt per symbol, followed by hand-written abort and
// reset sequences.
module tb_fountain_v1_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  rank;
  logic [15:0] drop_cnt;
  logic        done;

  int tests = 0;
  int failed = 0;

  fountain_v1_if #(.K(8), .W(64)) bus ();

  fountain_v1_decoder #(.K(8), .W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .rank(rank), .drop_cnt(drop_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mask;
    int          gen;
    bit          first;
    bit          last;
    int          ready_mode;
    logic [3:0]  exp_rank;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t tab [19];

  function automatic logic [63:0] srcv(input int gen, input int i);
    if (gen == 0) return 64'h1111_1111_1111_1111 * 64'(i);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(gen * 8 + i + 1);
  endfunction

  function automatic logic [63:0] enc(input int gen, input logic [7:0] m);
    logic [63:0] x = '0;
    for (int i = 0; i < 8; i++) if (m[i]) x ^= srcv(gen, i);
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] m, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.sym_ready) begin
      fail_now("send_wait");
    end else begin
      bus.sym_valid = 1'b1;
      bus.sym_mask  = m;
      bus.sym_data  = d;
      @(posedge clk);
      #1 bus.sym_valid = 1'b0;
      chk("sym_ready_in_reduce", bus.sym_ready, 0);
    end
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!(bus.sym_ready || bus.src_valid || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("settle");
  endtask

  // mode 0: consumer always ready; mode 1: ready one cycle in three.
  task automatic collect(input int gen, input int mode);
    int e = 0;
    int cyc = 0;
    while (e < 8 && cyc < 300) begin
      @(negedge clk);
      bus.src_ready = (mode == 0) || (cyc % 3 == 0);
      cyc++;
      if (bus.src_valid) begin
        chk("src_index", 64'(bus.src_index), 64'(e));
        chk("src_data", bus.src_data, srcv(gen, e));
        if (bus.src_ready) e++;
      end
    end
    chk("blocks_delivered", 64'(e), 64'd8);
    @(negedge clk);
    bus.src_ready = 1'b0;
    chk("done", done, 1);
    chk("src_valid_after_done", bus.src_valid, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sym_ready"}, bus.sym_ready, 0);
    chk({tag, "_src_valid"}, bus.src_valid, 0);
    chk({tag, "_src_index"}, 64'(bus.src_index), 0);
    chk({tag, "_src_data"}, bus.src_data, 0);
    chk({tag, "_rank"}, 64'(rank), 0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 0);
    chk({tag, "_done"}, done, 0);
  endtask

  localparam logic [7:0] CODED [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h01};

  initial begin
    logic [7:0] m;
    int n;
    bus.sym_valid = 1'b0;
    bus.sym_mask  = '0;
    bus.sym_data  = '0;
    bus.src_ready = 1'b0;

    // Generation 0: systematic; generation 1: coded with backpressure;
    // generation 2: redundant and zero symbols.
    for (int i = 0; i < 8; i++) begin
      m = 8'(1 << i);
      tab[i] = '{m, 0, i == 0, i == 7, 0, 4'(i + 1), 16'd0};
    end
    for (int i = 0; i < 8; i++)
      tab[8 + i] = '{CODED[i], 1, i == 0, i == 7, 1, 4'(i + 1), 16'd0};
    tab[16] = '{8'h05, 2, 1'b1, 1'b0, 0, 4'd1, 16'd0};
    tab[17] = '{8'h05, 2, 1'b0, 1'b0, 0, 4'd1, 16'd1};
    tab[18] = '{8'h00, 2, 1'b0, 1'b0, 0, 4'd1, 16'd2};

    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sym_ready", bus.sym_ready, 0);

    for (int v = 0; v < 19; v++) begin
      if (tab[v].first) pulse_start();
      send(tab[v].mask, enc(tab[v].gen, tab[v].mask));
      settle();
      chk("rank", 64'(rank), 64'(tab[v].exp_rank));
      chk("drop_cnt", 64'(drop_cnt), 64'(tab[v].exp_drop));
      if (tab[v].last) collect(tab[v].gen, tab[v].ready_mode);
    end

    // Abort in the middle of a multi-step reduction.
    send(8'h01, 64'hDEAD_0000_0000_BEEF);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("abort_red_rank", 64'(rank), 0);
    chk("abort_red_drop", 64'(drop_cnt), 0);
    chk("abort_red_src_valid", bus.src_valid, 0);
    chk("abort_red_sym_ready", bus.sym_ready, 1);

    // Abort in the middle of output.
    for (int i = 0; i < 8; i++) begin
      m = 8'(1 << i);
      send(m, enc(3, m));
      settle();
    end
    chk("pre_out_src_valid", bus.src_valid, 1);
    repeat (2) begin
      @(negedge clk);
      bus.src_ready = 1'b1;
    end
    @(negedge clk);
    bus.src_ready = 1'b0;
    chk("mid_out_index", 64'(bus.src_index), 2);
    chk("mid_out_data", bus.src_data, srcv(3, 2));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("abort_out_src_valid", bus.src_valid, 0);
    chk("abort_out_rank", 64'(rank), 0);
    chk("abort_out_done", done, 0);
    chk("abort_out_sym_ready", bus.sym_ready, 1);

    // Fresh generation after the abort.
    for (int i = 0; i < 8; i++) begin
      send(CODED[i], enc(4, CODED[i]));
      settle();
    end
    chk("fresh_rank", 64'(rank), 8);
    collect(4, 0);

    // Asynchronous reset during back-substitution.
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send(CODED[i], enc(1, CODED[i]));
      settle();
    end
    send(CODED[7], enc(1, CODED[7]));
    n = 0;
    while (rank != 4'd8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rank != 4'd8) fail_now("reach_backsub");
    chk("backsub_src_valid", bus.src_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.sym_valid = 1'b1;
    bus.sym_mask  = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_sym_ready", bus.sym_ready, 0);
      chk("post_rst_rank", 64'(rank), 0);
      chk("post_rst_src_valid", bus.src_valid, 0);
    end
    bus.sym_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
